range_filter_fifo: RTL and testbench

Ingress stage for the bench's byte traffic: accepts DW-bit samples on a valid/ready handshake, qualified by a half-rate sample enable. It keeps only samples inside a runtime-programmable inclusive window [lo:hi], buffers them in a small first-word-fall-through FIFO, and counts rejected samples. It sits directly upstream of the checking/consumer logic, which drains it through the output handshake on the same clock.

---
 rtl/range_filter_pkg.sv | 31 +++
 rtl/range_filter_fifo_sync_fifo.sv | 91 +++++++++
 rtl/range_filter_fifo.sv | 77 +++++++
 tb/tb_range_filter_fifo.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/range_filter_pkg.sv
// +-----------------------------------------------------------------------------
// | range_filter_pkg
// | Shared defaults, occupancy state encoding and window test for range_filter_fifo.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

package range_filter_pkg;

  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 4;
  localparam int CW_DEF    = 16;

  typedef logic [$clog2(DEPTH_DEF):0] count_t;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_t;

  // Operands are zero-extended by the caller so any DW up to 32 fits.
  function automatic bit in_window(input logic [31:0] data,
                                   input logic [31:0] lo,
                                   input logic [31:0] hi);
    return (data >= lo) && (data <= hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/range_filter_fifo_sync_fifo.sv
// +-----------------------------------------------------------------------------
// | sync_fifo
// | First-word-fall-through FIFO with separate occupancy count and state.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module sync_fifo
  import range_filter_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0]   c_cnt_one  = (AW + 1)'(1);
  localparam logic [AW:0]   c_cnt_last = (AW + 1)'(DEPTH - 1);
  localparam logic [AW-1:0] c_ptr_one  = AW'(1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  occ_state_t    r_state;
  logic          w_wr;
  logic          w_rd;

  assign w_wr  = push && (r_state != OCC_FULL);
  assign w_rd  = pop  && (r_state != OCC_EMPTY);
  assign rdata = r_mem[r_rd_ptr];
  assign count = r_count;
  // State tracks count exactly, so flags come straight from a register.
  assign full  = (r_state == OCC_FULL);
  assign empty = (r_state == OCC_EMPTY);

  // Storage has no reset; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_rd) r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= OCC_EMPTY;
    end else begin
      case (r_state)
        OCC_EMPTY: begin
          if (w_wr) r_state <= OCC_PARTIAL;
        end
        OCC_PARTIAL: begin
          if (w_wr && !w_rd && (r_count == c_cnt_last))
            r_state <= OCC_FULL;
          else if (w_rd && !w_wr && (r_count == c_cnt_one))
            r_state <= OCC_EMPTY;
        end
        OCC_FULL: begin
          if (w_rd) r_state <= OCC_PARTIAL;
        end
        default: r_state <= OCC_EMPTY;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/range_filter_fifo.sv
// +-----------------------------------------------------------------------------
// | range_filter_fifo
// | Enable-qualified ingress that keeps samples inside [lo:hi] and counts drops.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module range_filter_fifo
  import range_filter_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW-1:0]          in_data,
  input  logic [DW-1:0]          lo,
  input  logic [DW-1:0]          hi,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DW-1:0]          out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic [CW-1:0]          drop_cnt
);

  localparam logic [CW-1:0] c_drop_one = CW'(1);

  logic          w_full;
  logic          w_empty;
  logic          w_accept;
  logic          w_keep;
  logic          w_push;
  logic          w_drop;
  logic          w_pop;
  logic [CW-1:0] r_drop_cnt;

  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign drop_cnt  = r_drop_cnt;

  // An inverted window (lo > hi) never matches, so everything is dropped.
  assign w_accept = in_valid && in_ready && en;
  assign w_keep   = in_window(32'(in_data), 32'(lo), 32'(hi));
  assign w_push   = w_accept && w_keep;
  assign w_drop   = w_accept && !w_keep;
  assign w_pop    = out_valid && out_ready;

  sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .wdata (in_data),
    .pop   (w_pop),
    .rdata (out_data),
    .count (count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + c_drop_one;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_range_filter_fifo.sv
// +-----------------------------------------------------------------------------
// | tb_range_filter_fifo
// | Scenario tasks with a scoreboard queue for range_filter_fifo (CW=8).
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_range_filter_fifo;
  import range_filter_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [DW-1:0] lo;
  logic [DW-1:0] hi;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  count_t        count;
  logic [CW-1:0] drop_cnt;

  int            total = 0;
  int            bad   = 0;
  int            mcount = 0;
  int            mdrop  = 0;
  int            npops  = 0;
  logic          last_acc;
  logic [DW-1:0] exp_q[$];

  range_filter_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .lo        (lo),
    .hi        (hi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  assert property (@(posedge clk) disable iff (!rst_n) out_valid |-> !$isunknown(out_data));

  // Scoreboard consumer: whatever is at the head while popping must be the oldest kept sample.
  always @(negedge clk) begin
    #1;
    if (rst_n && out_valid && out_ready) begin
      total++;
      npops++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_underflow got=%0d want=<none>", out_data);
      end else begin
        logic [DW-1:0] want;
        want = exp_q.pop_front();
        if (out_data !== want) begin
          bad++;
          $display("FAIL scoreboard_data got=%0d want=%0d", out_data, want);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // Drive one cycle's inputs and advance the reference model for the coming edge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic e, input logic r);
    logic pop;
    logic keep;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    en        = e;
    out_ready = r;
    last_acc = v && e && (mcount < DEPTH);
    pop      = r && (mcount > 0);
    keep     = (d >= lo) && (d <= hi);
    if (last_acc && keep) exp_q.push_back(d);
    if (last_acc && !keep && mdrop < 255) mdrop++;
    mcount = mcount + ((last_acc && keep) ? 1 : 0) - (pop ? 1 : 0);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b1; in_data = 8'd20;
    lo = 8'd0; hi = 8'd255; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL reset_drop got=%0d want=0", drop_cnt); end
    rst_n = 1'b1; in_valid = 1'b0; en = 1'b0;
    idle();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_release_count got=%0d want=0", count); end
  endtask

  task automatic test_window();
    logic [DW-1:0] samples [5] = '{8'd3, 8'd15, 8'd20, 8'd31, 8'd32};
    lo = 8'd15; hi = 8'd31;
    for (int i = 0; i < 5; i++) step(1'b1, samples[i], 1'b1, 1'b0);
    idle();
    total++; if (count !== 3'd3) begin bad++; $display("FAIL window_count got=%0d want=3", count); end
    total++; if (drop_cnt !== 8'd2) begin bad++; $display("FAIL window_drop got=%0d want=2", drop_cnt); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL window_in_ready got=%0b want=1", in_ready); end
    total++; if (out_valid !== 1'b1 || out_data !== 8'd15) begin
      bad++; $display("FAIL window_head got=%0b/%0d want=1/15", out_valid, out_data);
    end
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1);
    idle();
    total++; if (out_valid !== 1'b0 || count !== 3'd0) begin
      bad++; $display("FAIL window_drained got=%0b/%0d want=0/0", out_valid, count);
    end
  endtask

  task automatic test_full_backpressure();
    lo = 8'd15; hi = 8'd31;
    for (int i = 16; i < 20; i++) step(1'b1, 8'(i), 1'b1, 1'b0);
    step(1'b1, 8'd20, 1'b1, 1'b0);
    #1;
    total++; if (count !== 3'd4 || in_ready !== 1'b0) begin
      bad++; $display("FAIL full_state got=%0d/%0b want=4/0", count, in_ready);
    end
    // Pop while full: 20 must stay upstream on this edge.
    step(1'b1, 8'd20, 1'b1, 1'b1);
    total++; if (last_acc !== 1'b0) begin bad++; $display("FAIL full_model got=%0b want=0", last_acc); end
    step(1'b1, 8'd20, 1'b1, 1'b0);
    #1;
    total++; if (count !== 3'd3) begin bad++; $display("FAIL full_pop_no_push got=%0d want=3", count); end
    idle();
    total++; if (count !== 3'd4) begin bad++; $display("FAIL full_refill got=%0d want=4", count); end
    total++; if (drop_cnt !== 8'd2) begin bad++; $display("FAIL full_drop got=%0d want=2", drop_cnt); end
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1);
    idle();
  endtask

  task automatic test_en_toggle();
    logic [DW-1:0] d;
    int p0;
    lo = 8'd0; hi = 8'd255; d = 8'd40; p0 = npops;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, d, (i % 2 == 1), 1'b1);
      if (last_acc) d++;
    end
    step(1'b0, '0, 1'b0, 1'b1);
    idle();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL en_count got=%0d want=0", count); end
    total++; if (npops - p0 != 5) begin bad++; $display("FAIL en_transfers got=%0d want=5", npops - p0); end
    total++; if (drop_cnt !== 8'd2) begin bad++; $display("FAIL en_drop got=%0d want=2", drop_cnt); end
  endtask

  task automatic test_empty_window();
    logic [DW-1:0] samples [3] = '{8'd20, 8'd15, 8'd31};
    lo = 8'd31; hi = 8'd15;
    for (int i = 0; i < 3; i++) step(1'b1, samples[i], 1'b1, 1'b0);
    idle();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL inv_count got=%0d want=0", count); end
    total++; if (drop_cnt !== 8'd5) begin bad++; $display("FAIL inv_drop got=%0d want=5", drop_cnt); end
    for (int i = 0; i < 300; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0);
    idle();
    total++; if (drop_cnt !== 8'd255) begin bad++; $display("FAIL drop_saturate got=%0d want=255", drop_cnt); end
    total++; if (drop_cnt !== 8'(mdrop)) begin bad++; $display("FAIL drop_model got=%0d want=%0d", drop_cnt, mdrop); end
  endtask

  task automatic test_back_to_back_wrap();
    int p0;
    lo = 8'd0; hi = 8'd255; p0 = npops;
    for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom), 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    idle();
    total++; if (npops - p0 != 10) begin bad++; $display("FAIL wrap_pops got=%0d want=10", npops - p0); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL wrap_count got=%0d want=0", count); end
  endtask

  task automatic test_async_reset();
    lo = 8'd0; hi = 8'd255;
    step(1'b1, 8'd7, 1'b1, 1'b0);
    step(1'b1, 8'd9, 1'b1, 1'b0);
    idle();
    total++; if (count !== 3'd2) begin bad++; $display("FAIL mid_pre_count got=%0d want=2", count); end
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (count !== 3'd0 || out_valid !== 1'b0 || drop_cnt !== 8'd0) begin
      bad++; $display("FAIL mid_reset got=%0d/%0b/%0d want=0/0/0", count, out_valid, drop_cnt);
    end
    exp_q.delete(); mcount = 0; mdrop = 0;
    @(negedge clk); rst_n = 1'b1;
    step(1'b1, 8'd11, 1'b1, 1'b0);
    step(1'b1, 8'd12, 1'b1, 1'b0);
    idle();
    total++; if (count !== 3'd2 || out_data !== 8'd11) begin
      bad++; $display("FAIL mid_resume got=%0d/%0d want=2/11", count, out_data);
    end
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    idle();
    total++; if (exp_q.size() != 0 || count !== 3'd0) begin
      bad++; $display("FAIL final_empty got=%0d/%0d want=0/0", exp_q.size(), count);
    end
  endtask

  initial begin
    test_reset();
    test_window();
    test_full_backpressure();
    test_en_toggle();
    test_empty_window();
    test_back_to_back_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
